stream_mux_rr: RTL and testbench

Parametrised N:1 streaming multiplexer with a registered output, valid/ready handshaking on every channel, and a runtime choice between fixed selection and round-robin arbitration. It generalises the 16-bit 2:1 datapath mux into a buffered, flow-controlled selector. It sits between several producers (register-file read ports, memory/IO responders) and a single consumer on the 16-bit datapath.

---
 rtl/stream_mux_rr.sv | 84 ++++++++
 tb/tb_stream_mux_rr.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_mux_rr.sv
// N:1 valid/ready stream multiplexer with a registered output stage.
// Channel choice is either a fixed selector or round-robin starting after the last served channel.
module stream_mux_rr #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4,
    localparam int SEL_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          selector,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_channel,
    output logic                      out_valid,
    input  logic                      out_ready
);

    logic [SEL_W-1:0] last;
    logic [SEL_W-1:0] grant_idx;
    logic             grant_valid;
    logic             can_accept;
    logic             accept;
    logic [WIDTH-1:0] sel_data;
    int unsigned      idx;

    assign can_accept = !out_valid || out_ready;
    assign accept     = grant_valid && can_accept;

    // Round-robin search visits last+1 .. last (wrapping), so the most recently
    // served channel has the lowest priority.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        if (!mode) begin
            if (32'(selector) < CHANNELS) begin
                grant_valid = in_valid[selector];
                grant_idx   = selector;
            end
        end else begin
            for (int unsigned k = 1; k <= CHANNELS; k++) begin
                idx = 32'(last) + k;
                if (idx >= CHANNELS) begin
                    idx = idx - CHANNELS;
                end
                if (!grant_valid && in_valid[idx[SEL_W-1:0]]) begin
                    grant_valid = 1'b1;
                    grant_idx   = idx[SEL_W-1:0];
                end
            end
        end
    end

    always_comb begin
        sel_data = '0;
        in_ready = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (grant_idx == i[SEL_W-1:0]) begin
                sel_data    = in_data[i*WIDTH +: WIDTH];
                in_ready[i] = rst_n && accept;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_channel <= '0;
            last        <= SEL_W'(CHANNELS - 1);
        end else if (accept) begin
            out_valid   <= 1'b1;
            out_data    <= sel_data;
            out_channel <= grant_idx;
            last        <= grant_idx;
        end else if (out_ready) begin
            out_valid   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: reset, fixed select, round-robin, skip/wrap,
// backpressure and asynchronous reset in the middle of a stream.
module tb_stream_mux_rr;

    localparam int WIDTH    = 16;
    localparam int CHANNELS = 4;
    localparam int SEL_W    = 2;

    logic                      clk;
    logic                      rst_n;
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS-1:0]       in_ready;
    logic                      mode;
    logic [SEL_W-1:0]          selector;
    logic [WIDTH-1:0]          out_data;
    logic [SEL_W-1:0]          out_channel;
    logic                      out_valid;
    logic                      out_ready;

    int errors = 0;
    int checks = 0;

    stream_mux_rr #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .mode       (mode),
        .selector   (selector),
        .out_data   (out_data),
        .out_channel(out_channel),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input logic [15:0] w0, input logic [15:0] w1,
                            input logic [15:0] w2, input logic [15:0] w3);
        in_data = {w3, w2, w1, w0};
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        mode      = 1'b1;
        selector  = 2'd1;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        set_data(16'hAAAA, 16'h5555, 16'h1234, 16'hFFFF);
        #2;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++;
        if (out_data !== 16'h0000) begin errors++; $display("FAIL reset_out_data got=%h exp=0000", out_data); end
        checks++;
        if (out_channel !== 2'd0) begin errors++; $display("FAIL reset_out_channel got=%0d exp=0", out_channel); end
        checks++;
        if (in_ready !== 4'b0000) begin errors++; $display("FAIL reset_in_ready got=%b exp=0000", in_ready); end
        step();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_hold_valid got=%b exp=0", out_valid); end
        in_valid = 4'b0100;
        set_data(16'h0000, 16'h0000, 16'hBEEF, 16'h0000);
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 4'b0100) begin errors++; $display("FAIL release_in_ready got=%b exp=0100", in_ready); end
        step();
        checks++;
        if (out_valid !== 1'b1 || out_channel !== 2'd2 || out_data !== 16'hBEEF) begin
            errors++;
            $display("FAIL release_first got=%b/%0d/%h exp=1/2/beef", out_valid, out_channel, out_data);
        end
    endtask

    task automatic test_fixed_select();
        mode     = 1'b0;
        selector = 2'd1;
        in_valid = 4'b1111;
        set_data(16'h0001, 16'h0002, 16'h0003, 16'h0004);
        #1;
        checks++;
        if (in_ready !== 4'b0010) begin errors++; $display("FAIL fixed_in_ready got=%b exp=0010", in_ready); end
        step();
        checks++;
        if (out_data !== 16'h0002 || out_channel !== 2'd1 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL fixed_sel1 got=%h/%0d/%b exp=0002/1/1", out_data, out_channel, out_valid);
        end
        selector = 2'd0;
        #1;
        checks++;
        if (in_ready !== 4'b0001) begin errors++; $display("FAIL fixed_sel0_ready got=%b exp=0001", in_ready); end
        step();
        checks++;
        if (out_data !== 16'h0001 || out_channel !== 2'd0) begin
            errors++;
            $display("FAIL fixed_sel0 got=%h/%0d exp=0001/0", out_data, out_channel);
        end
        selector = 2'd3;
        step();
        checks++;
        if (out_data !== 16'h0004 || out_channel !== 2'd3) begin
            errors++;
            $display("FAIL fixed_sel3 got=%h/%0d exp=0004/3", out_data, out_channel);
        end
        // Selected channel not valid: others must not be granted, output drains.
        selector = 2'd2;
        in_valid = 4'b1011;
        #1;
        checks++;
        if (in_ready !== 4'b0000) begin errors++; $display("FAIL fixed_nogrant_ready got=%b exp=0000", in_ready); end
        step();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 16'h0004) begin
            errors++;
            $display("FAIL fixed_drain got=%b/%h exp=0/0004", out_valid, out_data);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_ch;
        mode     = 1'b1;
        in_valid = 4'b1111;
        set_data(16'h0010, 16'h0011, 16'h0012, 16'h0013);
        for (int i = 0; i < 6; i++) begin
            exp_ch = 2'(i % 4);
            #1;
            checks++;
            if (in_ready !== (4'b0001 << exp_ch)) begin
                errors++;
                $display("FAIL rr_ready[%0d] got=%b exp_ch=%0d", i, in_ready, exp_ch);
            end
            step();
            checks++;
            if (out_valid !== 1'b1 || out_channel !== exp_ch || out_data !== (16'h0010 + 16'(exp_ch))) begin
                errors++;
                $display("FAIL rr_out[%0d] got=%b/%0d/%h exp=1/%0d/%h", i, out_valid, out_channel,
                         out_data, exp_ch, 16'h0010 + 16'(exp_ch));
            end
        end
    endtask

    task automatic test_skip_wrap();
        logic [1:0] exp_seq [4];
        exp_seq = '{2'd2, 2'd0, 2'd2, 2'd0};
        in_valid = 4'b0101;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b1 || out_channel !== exp_seq[i]) begin
                errors++;
                $display("FAIL skip[%0d] got=%b/%0d exp=1/%0d", i, out_valid, out_channel, exp_seq[i]);
            end
        end
        in_valid = 4'b1000;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b1 || out_channel !== 2'd3 || out_data !== 16'h0013) begin
                errors++;
                $display("FAIL only3[%0d] got=%b/%0d/%h exp=1/3/0013", i, out_valid, out_channel, out_data);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] exp_words [5];
        logic [15:0] got_words [5];
        exp_words = '{16'h0010, 16'h0011, 16'h0012, 16'h0013, 16'h0010};
        in_valid = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            step();
            got_words[i] = out_data;
        end
        out_ready = 1'b0;
        #1;
        checks++;
        if (in_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready got=%b exp=0000", in_ready); end
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b1 || out_data !== 16'h0012 || out_channel !== 2'd2 || in_ready !== 4'b0000) begin
                errors++;
                $display("FAIL bp_hold[%0d] got=%b/%h/%0d/%b exp=1/0012/2/0000", i, out_valid, out_data,
                         out_channel, in_ready);
            end
        end
        out_ready = 1'b1;
        for (int i = 3; i < 5; i++) begin
            step();
            got_words[i] = out_data;
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (got_words[i] !== exp_words[i]) begin
                errors++;
                $display("FAIL bp_stream[%0d] got=%h exp=%h", i, got_words[i], exp_words[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        step();
        checks++;
        if (out_channel !== 2'd1 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL ar_pre got=%0d/%b exp=1/1", out_channel, out_valid);
        end
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 4'b0000 || out_data !== 16'h0000) begin
            errors++;
            $display("FAIL ar_assert got=%b/%b/%h exp=0/0000/0000", out_valid, in_ready, out_data);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 4'b0001) begin errors++; $display("FAIL ar_release_ready got=%b exp=0001", in_ready); end
        step();
        checks++;
        if (out_channel !== 2'd0 || out_data !== 16'h0010 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL ar_first got=%0d/%h/%b exp=0/0010/1", out_channel, out_data, out_valid);
        end
        step();
        checks++;
        if (out_channel !== 2'd1 || out_data !== 16'h0011) begin
            errors++;
            $display("FAIL ar_second got=%0d/%h exp=1/0011", out_channel, out_data);
        end
    endtask

    initial begin
        test_reset();
        test_fixed_select();
        test_round_robin();
        test_skip_wrap();
        test_backpressure();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
